// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port unified memory between the fetch (I) and memory (D) stages.
// D has priority; a saturating starvation counter forces an I grant after STARVE_MAX D grants.
module unified_mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic [DATA_W-1:0] irdata_o,
  output logic              iready_o,
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic [DATA_W-1:0] drdata_o,
  output logic              dready_o,
  output logic              stallf_o,
  output logic              stallm_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic win_i;
  logic win_d;

  // Grants are decided in IDLE or on the ack cycle so transactions chain without a bubble.
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq_i && !(ireq_i && starve_cnt_q == CNT_MAX)) win_d = 1'b1;
        else if (ireq_i)                                      win_i = 1'b1;
      end
      BUSY_I:  win_d = mem_ack_i && dreq_i;
      BUSY_D:  win_i = mem_ack_i && ireq_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else if (win_d) begin
      state_q     <= BUSY_D;
      mem_req_q   <= 1'b1;
      mem_we_q    <= dwe_i;
      mem_addr_q  <= daddr_i;
      mem_wdata_q <= dwdata_i;
      if (!ireq_i)                    starve_cnt_q <= '0;
      else if (starve_cnt_q != CNT_MAX) starve_cnt_q <= starve_cnt_q + 1'b1;
    end else if (win_i) begin
      state_q      <= BUSY_I;
      mem_req_q    <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= iaddr_i;
      starve_cnt_q <= '0;
    end else if (state_q != IDLE && mem_ack_i) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
    end
  end

  // Ready is suppressed while reset is asserted so an abandoned transaction never completes.
  assign iready_o = mem_ack_i && (state_q == BUSY_I) && !reset_i;
  assign dready_o = mem_ack_i && (state_q == BUSY_D) && !reset_i;
  assign irdata_o = mem_rdata_i;
  assign drdata_o = mem_rdata_i;

  assign stallf_o = ireq_i && !iready_o;
  assign stallm_o = dreq_i && !dready_o;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized checks of unified_mem_arbiter against a transaction-level model
// that tracks which port owns the memory and how many D grants have starved fetch.
module tb_unified_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          ireq_i;
  logic [AW-1:0] iaddr_i;
  logic [DW-1:0] irdata_o;
  logic          iready_o;
  logic          dreq_i;
  logic          dwe_i;
  logic [AW-1:0] daddr_i;
  logic [DW-1:0] dwdata_i;
  logic [DW-1:0] drdata_o;
  logic          dready_o;
  logic          stallf_o;
  logic          stallm_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;

  unified_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(MAX)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .irdata_o(irdata_o), .iready_o(iready_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
    .drdata_o(drdata_o), .dready_o(dready_o),
    .stallf_o(stallf_o), .stallm_o(stallm_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner of the memory (0 none, 1 fetch, 2 data), starvation tally, and the
  // transaction the memory is currently being asked to perform.
  int            m_own;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_starve = 0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
  endtask

  task automatic give_to(input int who);
    m_own = who;
    if (who == 1) begin
      m_addr = iaddr_i; m_we = 1'b0; m_starve = 0;
    end else begin
      m_addr = daddr_i; m_we = dwe_i; m_wdata = dwdata_i;
      m_starve = ireq_i ? ((m_starve < MAX) ? m_starve + 1 : MAX) : 0;
    end
  endtask

  task automatic model_edge();
    int nxt;
    if (reset_i) begin
      model_reset();
    end else if (m_own == 0) begin
      if (dreq_i && !(ireq_i && m_starve == MAX)) give_to(2);
      else if (ireq_i)                             give_to(1);
    end else if (mem_ack_i) begin
      // the port that just finished hands over to the other one if it is waiting
      nxt = (m_own == 1) ? (dreq_i ? 2 : 0) : (ireq_i ? 1 : 0);
      if (nxt != 0) give_to(nxt);
      else          m_own = 0;
    end
  endtask

  task automatic check_all();
    logic e_ir, e_dr;
    e_ir = mem_ack_i && !reset_i && m_own == 1;
    e_dr = mem_ack_i && !reset_i && m_own == 2;
    chk("mem_req", 32'(mem_req_o), 32'(m_own != 0));
    chk("iready",  32'(iready_o),  32'(e_ir));
    chk("dready",  32'(dready_o),  32'(e_dr));
    chk("stallf",  32'(stallf_o),  32'(ireq_i && !e_ir));
    chk("stallm",  32'(stallm_o),  32'(dreq_i && !e_dr));
    if (m_own != 0) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we",   32'(mem_we_o), 32'(m_we));
    end
    if (m_own == 2) chk("mem_wdata", mem_wdata_o, m_wdata);
    if (e_ir) chk("irdata", irdata_o, mem_rdata_i);
    if (e_dr) chk("drdata", drdata_o, mem_rdata_i);
  endtask

  task automatic step();
    @(negedge clk_i);
    check_all();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; ireq_i = 1'b1; iaddr_i = 32'h10; dreq_i = 1'b0; dwe_i = 1'b0;
    daddr_i = '0; dwdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    model_reset();

    // reset held with a pending fetch
    step();
    chk("t1_memreq_in_reset", 32'(mem_req_o), 32'h0);
    chk("t1_stallf_in_reset", 32'(stallf_o), 32'h1);
    step();
    reset_i = 1'b0;
    #1 chk("t1_memreq_after_release", 32'(mem_req_o), 32'h0);
    step();

    // fetch at 0x10, ack one cycle after MemReq
    chk("t2_memreq", 32'(mem_req_o), 32'h1);
    chk("t2_addr", mem_addr_o, 32'h10);
    chk("t2_we", 32'(mem_we_o), 32'h0);
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hE3A01005;
    #1 chk("t2_iready", 32'(iready_o), 32'h1);
    chk("t2_irdata", irdata_o, 32'hE3A01005);
    step();
    ireq_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // store 0x7 to 0x64
    dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h64; dwdata_i = 32'h7;
    step();
    chk("t3_we", 32'(mem_we_o), 32'h1);
    chk("t3_addr", mem_addr_o, 32'h64);
    chk("t3_wdata", mem_wdata_o, 32'h7);
    mem_ack_i = 1'b1;
    #1 chk("t3_dready", 32'(dready_o), 32'h1);
    step();
    dreq_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // simultaneous requests: D first, then I with no gap
    ireq_i = 1'b1; iaddr_i = 32'h20; dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h80;
    step();
    chk("t4_d_first", mem_addr_o, 32'h80);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1 chk("t4_stallf_during_d", 32'(stallf_o), 32'h1);
    step();
    dreq_i = 1'b0; mem_ack_i = 1'b0;
    #1 chk("t4_no_bubble", 32'(mem_req_o), 32'h1);
    chk("t4_i_second", mem_addr_o, 32'h20);
    step();
    mem_ack_i = 1'b1;
    #1 chk("t4_iready", 32'(iready_o), 32'h1);
    step();
    ireq_i = 1'b0; mem_ack_i = 1'b0;
    step();

    // starvation: four D grants while fetch waits, then fetch is forced
    for (int k = 0; k < MAX; k++) begin
      ireq_i = 1'b1; iaddr_i = 32'h200; dreq_i = 1'b1; daddr_i = 32'h100 + 32'(k);
      step();
      chk("t5_d_wins", mem_addr_o, 32'h100 + 32'(k));
      mem_ack_i = 1'b1; ireq_i = 1'b0;
      step();
      mem_ack_i = 1'b0; dreq_i = 1'b0;
      step();
    end
    ireq_i = 1'b1; dreq_i = 1'b1; daddr_i = 32'h1FC;
    step();
    chk("t5_i_forced", mem_addr_o, 32'h200);
    chk("t5_i_we", 32'(mem_we_o), 32'h0);
    mem_ack_i = 1'b1; dreq_i = 1'b0;
    step();
    mem_ack_i = 1'b0; dreq_i = 1'b1;
    step();
    chk("t5_cnt_cleared", mem_addr_o, 32'h1FC);
    mem_ack_i = 1'b1; ireq_i = 1'b0;
    step();
    mem_ack_i = 1'b0; dreq_i = 1'b0;
    step();

    // reset in BUSY_D before ack, then a stray ack in IDLE
    dreq_i = 1'b1; dwe_i = 1'b1; daddr_i = 32'h300; dwdata_i = 32'hAB;
    step();
    reset_i = 1'b1;
    #1 chk("t6_no_dready_in_reset", 32'(dready_o), 32'h0);
    step();
    reset_i = 1'b0; dreq_i = 1'b0; mem_ack_i = 1'b1;
    #1 chk("t6_memreq_cleared", 32'(mem_req_o), 32'h0);
    chk("t6_ack_in_idle", 32'(dready_o), 32'h0);
    step();
    mem_ack_i = 1'b0;
    step();

    // randomized traffic, including dropped requests and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(3) == 0) ireq_i = ~ireq_i;
      if ($urandom_range(2) == 0) dreq_i = ~dreq_i;
      iaddr_i     = $urandom;
      daddr_i     = $urandom;
      dwdata_i    = $urandom;
      dwe_i       = 1'($urandom_range(1));
      mem_rdata_i = $urandom;
      mem_ack_i   = (m_own != 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      reset_i     = ($urandom_range(199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
